// File: rtl/pueo_command_encoder_pkg.sv
// -----------------------------------------------------------------------------
// pueo_command_pkg
// Shared constants and the SURF command word layout used by the TURFIO-side
// command encoder and its mode1 arbiter.
//   RUNCMD_*       : 2-bit run command codes carried in the message field
//   MODE1TYPE_*    : 2-bit mode1 type codes
//   MODE1SPECIAL_* : 8-bit mode1 special codes
//   cmd_word_t     : packed 32-bit command word, MSB first
// -----------------------------------------------------------------------------
package pueo_command_pkg;

  localparam logic [1:0] RUNCMD_NOOP_LIVE = 2'b00;
  localparam logic [1:0] RUNCMD_DO_SYNC   = 2'b01;
  localparam logic [1:0] RUNCMD_RESET     = 2'b10;
  localparam logic [1:0] RUNCMD_STOP      = 2'b11;

  localparam logic [1:0] MODE1TYPE_SPECIAL = 2'b00;
  localparam logic [1:0] MODE1TYPE_CMDPROC = 2'b01;
  localparam logic [1:0] MODE1TYPE_RSVD    = 2'b10;
  // Firmware bytes and the final cmdproc byte of a packet share this type.
  localparam logic [1:0] MODE1TYPE_FW_LAST = 2'b11;

  localparam logic [7:0] MODE1SPECIAL_NULL      = 8'h00;
  localparam logic [7:0] MODE1SPECIAL_RESET     = 8'h01;
  localparam logic [7:0] MODE1SPECIAL_FW_MARK_A = 8'h02;
  localparam logic [7:0] MODE1SPECIAL_FW_MARK_B = 8'h03;

  typedef struct packed {
    logic        msg_n;      // 1 = idle frame, 0 = message frame
    logic [2:0]  rsvd_hi;
    logic [1:0]  runcmd;
    logic [1:0]  m1type;
    logic [7:0]  m1data;
    logic        trig;
    logic        rsvd_lo;
    logic [13:0] trig_time;
  } cmd_word_t;

  localparam logic [31:0] CMD_IDLE_WORD = 32'h8000_0000;

endpackage

// File: rtl/pueo_command_encoder_if.sv
// -----------------------------------------------------------------------------
// pueo_command_encoder_if
// Groups every request/ready source and the frame word output of the command
// encoder. The master modport is the side that drives the request inputs and
// consumes the frame word; the slave modport is the encoder itself.
//   trig_*    : trigger request (14-bit time)
//   runcmd_*  : run command request
//   special_* : mode1 special code request
//   fw_*      : firmware upgrade byte stream
//   cmd_*     : cmdproc byte stream with packet-last flag
//   command_* : 32-bit frame word and its first-cycle strobe
// -----------------------------------------------------------------------------
interface pueo_command_encoder_if;
  logic [13:0] trig_time_i;
  logic        trig_valid_i;
  logic        trig_ready_o;
  logic [1:0]  runcmd_i;
  logic        runcmd_valid_i;
  logic        runcmd_ready_o;
  logic [7:0]  special_i;
  logic        special_valid_i;
  logic        special_ready_o;
  logic [7:0]  fw_tdata;
  logic        fw_tvalid;
  logic        fw_tready;
  logic [7:0]  cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tlast;
  logic        cmd_tready;
  logic [31:0] command_o;
  logic        command_valid_o;

  modport master (
    output trig_time_i, trig_valid_i, runcmd_i, runcmd_valid_i,
           special_i, special_valid_i, fw_tdata, fw_tvalid,
           cmd_tdata, cmd_tvalid, cmd_tlast,
    input  trig_ready_o, runcmd_ready_o, special_ready_o, fw_tready,
           cmd_tready, command_o, command_valid_o
  );

  modport slave (
    input  trig_time_i, trig_valid_i, runcmd_i, runcmd_valid_i,
           special_i, special_valid_i, fw_tdata, fw_tvalid,
           cmd_tdata, cmd_tvalid, cmd_tlast,
    output trig_ready_o, runcmd_ready_o, special_ready_o, fw_tready,
           cmd_tready, command_o, command_valid_o
  );
endinterface

// File: rtl/pueo_command_encoder_mode1_arb.sv
// -----------------------------------------------------------------------------
// pueo_cmd_mode1_arb
// Fixed-priority selector for the mode1 slot of a command frame
// (special > firmware > cmdproc). Purely combinational.
//   load_i           : high in the LOAD cycle; readies are only issued then
//   special_*_i      : special code request
//   fw_*_i           : firmware byte request
//   cmd_*_i          : cmdproc byte request (+ last flag)
//   *_ready_o        : accept strobes, at most one high per LOAD
//   m1_valid_o       : a mode1 source is pending this cycle
//   m1_type_o/data_o : selected mode1 type and byte (null special when idle)
// -----------------------------------------------------------------------------
module pueo_cmd_mode1_arb
  import pueo_command_pkg::*;
(
  input  logic       load_i,
  input  logic [7:0] special_i,
  input  logic       special_valid_i,
  input  logic [7:0] fw_tdata_i,
  input  logic       fw_tvalid_i,
  input  logic [7:0] cmd_tdata_i,
  input  logic       cmd_tvalid_i,
  input  logic       cmd_tlast_i,
  output logic       special_ready_o,
  output logic       fw_tready_o,
  output logic       cmd_tready_o,
  output logic       m1_valid_o,
  output logic [1:0] m1_type_o,
  output logic [7:0] m1_data_o
);

  logic sel_special;
  logic sel_fw;
  logic sel_cmd;

  assign sel_special = special_valid_i;
  assign sel_fw      = fw_tvalid_i && !special_valid_i;
  assign sel_cmd     = cmd_tvalid_i && !special_valid_i && !fw_tvalid_i;

  assign special_ready_o = load_i && sel_special;
  assign fw_tready_o     = load_i && sel_fw;
  assign cmd_tready_o    = load_i && sel_cmd;
  assign m1_valid_o      = sel_special || sel_fw || sel_cmd;

  always_comb begin
    m1_type_o = MODE1TYPE_SPECIAL;
    m1_data_o = MODE1SPECIAL_NULL;
    if (sel_special) begin
      m1_type_o = MODE1TYPE_SPECIAL;
      m1_data_o = special_i;
    end else if (sel_fw) begin
      m1_type_o = MODE1TYPE_FW_LAST;
      m1_data_o = fw_tdata_i;
    end else if (sel_cmd) begin
      m1_type_o = cmd_tlast_i ? MODE1TYPE_FW_LAST : MODE1TYPE_CMDPROC;
      m1_data_o = cmd_tdata_i;
    end
  end

endmodule

// File: rtl/pueo_command_encoder.sv
// -----------------------------------------------------------------------------
// pueo_command_encoder
// Builds one 32-bit SURF command word per frame of FRAME_LEN sysclk cycles.
// The word is registered in the last cycle of the frame (LOAD) and held for
// the whole next frame; command_valid_o strobes in its first cycle.
//   sysclk_i : system clock
//   rst_i    : asynchronous active-high reset (output returns to idle)
//   bus      : request sources, readies and frame word (slave modport)
// Parameters:
//   FRAME_LEN   : cycles per frame (>= 4)
//   LIVE_PERIOD : frames between forced NOOP_LIVE keepalives, 0 = never
//   DEBUG       : "TRUE" keeps the phase counter visible for an ILA
// -----------------------------------------------------------------------------
module pueo_command_encoder
  import pueo_command_pkg::*;
#(
  parameter int FRAME_LEN   = 8,
  parameter int LIVE_PERIOD = 16,
  parameter     DEBUG       = "TRUE"
) (
  input logic                   sysclk_i,
  input logic                   rst_i,
  pueo_command_encoder_if.slave bus
);

  localparam int PW         = $clog2(FRAME_LEN);
  localparam int LW         = (LIVE_PERIOD > 1) ? $clog2(LIVE_PERIOD) : 1;
  localparam int LIVE_LAST  = (LIVE_PERIOD > 0) ? LIVE_PERIOD - 1 : 0;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FRAME_LEN - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [LW-1:0] live_q, live_d;
  cmd_word_t     command_q, command_d;
  logic          valid_q, valid_d;

  logic          load;
  logic          keep_due;
  logic          msg_frame;
  logic          m1_valid;
  logic [1:0]    m1_type;
  logic [7:0]    m1_data;

  if (DEBUG == "TRUE") begin : g_keep
    (* keep = "true" *) logic [PW-1:0] phase_keep;
    assign phase_keep = phase_q;
    assign load       = (phase_keep == PHASE_LAST);
  end else begin : g_plain
    assign load = (phase_q == PHASE_LAST);
  end

  pueo_cmd_mode1_arb u_mode1_arb (
    .load_i          (load),
    .special_i       (bus.special_i),
    .special_valid_i (bus.special_valid_i),
    .fw_tdata_i      (bus.fw_tdata),
    .fw_tvalid_i     (bus.fw_tvalid),
    .cmd_tdata_i     (bus.cmd_tdata),
    .cmd_tvalid_i    (bus.cmd_tvalid),
    .cmd_tlast_i     (bus.cmd_tlast),
    .special_ready_o (bus.special_ready_o),
    .fw_tready_o     (bus.fw_tready),
    .cmd_tready_o    (bus.cmd_tready),
    .m1_valid_o      (m1_valid),
    .m1_type_o       (m1_type),
    .m1_data_o       (m1_data)
  );

  // Run and trigger slots always take their request in LOAD; they never
  // compete with each other or with the mode1 slot.
  assign bus.trig_ready_o   = load && bus.trig_valid_i;
  assign bus.runcmd_ready_o = load && bus.runcmd_valid_i;

  assign keep_due  = (LIVE_PERIOD != 0) && (live_q == LW'(LIVE_LAST));
  assign msg_frame = bus.runcmd_valid_i || m1_valid || keep_due;

  always_comb begin
    command_d       = cmd_word_t'(CMD_IDLE_WORD);
    command_d.msg_n = !msg_frame;
    if (msg_frame) begin
      command_d.runcmd = bus.runcmd_valid_i ? bus.runcmd_i : RUNCMD_NOOP_LIVE;
      command_d.m1type = m1_type;
      command_d.m1data = m1_data;
    end
    if (bus.trig_valid_i) begin
      command_d.trig      = 1'b1;
      command_d.trig_time = bus.trig_time_i;
    end
  end

  always_comb begin
    phase_d = load ? '0 : phase_q + 1'b1;
    valid_d = load;
    live_d  = live_q;
    if (load) begin
      // Any message frame (including a forced keepalive) restarts the count.
      live_d = msg_frame ? '0 : live_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q   <= '0;
      live_q    <= '0;
      valid_q   <= 1'b0;
      command_q <= cmd_word_t'(CMD_IDLE_WORD);
    end else begin
      phase_q <= phase_d;
      live_q  <= live_d;
      valid_q <= valid_d;
      if (load) begin
        command_q <= command_d;
      end
    end
  end

  assign bus.command_o       = command_q;
  assign bus.command_valid_o = valid_q;

endmodule

// File: tb/tb_pueo_command_encoder.sv
module tb_pueo_command_encoder;

  localparam logic [31:0] IDLE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pueo_command_encoder_if bus();

  pueo_command_encoder #(
    .FRAME_LEN   (8),
    .LIVE_PERIOD (16),
    .DEBUG       ("TRUE")
  ) dut (
    .sysclk_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          live_m = 0;
  logic [31:0] last_word = IDLE;
  logic [31:0] exp_w;

  // Scoreboard monitor: pops one expected word per strobe and checks that
  // the word holds between strobes.
  always @(negedge clk) begin
    if (rst) begin
      last_word = IDLE;
    end else if (bus.command_valid_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected got %08h required none", bus.command_o);
      end else begin
        exp_w = exp_q.pop_front();
        if (bus.command_o !== exp_w) begin
          errors++;
          $display("FAIL word got %08h required %08h", bus.command_o, exp_w);
        end else begin
          $display("word %08h ok", bus.command_o);
        end
      end
      last_word = bus.command_o;
    end else begin
      checks++;
      if (bus.command_o !== last_word) begin
        errors++;
        $display("FAIL word_hold got %08h required %08h", bus.command_o, last_word);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model of one frame word; tracks the keepalive count.
  function automatic logic [31:0] model_word(
    input logic tv, input logic [13:0] tt,
    input logic rv, input logic [1:0] rc,
    input logic sv, input logic [7:0] sp,
    input logic fv, input logic [7:0] fd,
    input logic cv, input logic [7:0] cd, input logic cl);
    logic [15:0] hi, lo;
    logic [1:0]  ty;
    logic [7:0]  da;
    logic        msg;
    ty = 2'b00; da = 8'h00;
    if (sv)      begin ty = 2'b00; da = sp; end
    else if (fv) begin ty = 2'b11; da = fd; end
    else if (cv) begin ty = cl ? 2'b11 : 2'b01; da = cd; end
    msg = rv || sv || fv || cv || (live_m == 15);
    hi  = msg ? {4'b0000, (rv ? rc : 2'b00), ty, da} : 16'h8000;
    lo  = tv ? {2'b10, tt} : 16'h0000;
    live_m = msg ? 0 : live_m + 1;
    return {hi, lo};
  endfunction

  function automatic logic [4:0] readies();
    return {bus.trig_ready_o, bus.runcmd_ready_o, bus.special_ready_o,
            bus.fw_tready, bus.cmd_tready};
  endfunction

  task automatic clear_inputs();
    bus.trig_valid_i = 0; bus.runcmd_valid_i = 0; bus.special_valid_i = 0;
    bus.fw_tvalid = 0; bus.cmd_tvalid = 0; bus.cmd_tlast = 0;
  endtask

  // Called at the phase-0 sample point; returns at the next phase-0 sample
  // point with the readies seen in LOAD and OR-ed over the other phases.
  task automatic drive_frame(
    input int start_phase,
    input logic tv, input logic [13:0] tt,
    input logic rv, input logic [1:0] rc,
    input logic sv, input logic [7:0] sp,
    input logic fv, input logic [7:0] fd,
    input logic cv, input logic [7:0] cd, input logic cl,
    output logic [4:0] rdy_load, output logic [4:0] rdy_early);
    rdy_early = 5'b0;
    for (int p = 0; p < 7; p++) begin
      if (p == start_phase) begin
        bus.trig_time_i = tt; bus.trig_valid_i = tv;
        bus.runcmd_i = rc; bus.runcmd_valid_i = rv;
        bus.special_i = sp; bus.special_valid_i = sv;
        bus.fw_tdata = fd; bus.fw_tvalid = fv;
        bus.cmd_tdata = cd; bus.cmd_tvalid = cv; bus.cmd_tlast = cl;
      end
      #1;
      rdy_early = rdy_early | readies();
      @(negedge clk);
    end
    #1;
    rdy_load = readies();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    int lat;
    bus.trig_time_i = 14'h3FFF; bus.trig_valid_i = 1;
    bus.runcmd_i = 2'b11; bus.runcmd_valid_i = 1;
    bus.special_i = 8'h01; bus.special_valid_i = 1;
    bus.fw_tdata = 8'hFF; bus.fw_tvalid = 1;
    bus.cmd_tdata = 8'hFF; bus.cmd_tvalid = 1; bus.cmd_tlast = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.command_o !== IDLE) begin
      errors++; $display("FAIL reset_word got %08h required %08h", bus.command_o, IDLE);
    end
    checks++;
    if (bus.command_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b required 0", bus.command_valid_o);
    end
    checks++;
    if (readies() !== 5'b0) begin
      errors++; $display("FAIL reset_ready got %b required 00000", readies());
    end
    $display("reset state checked");
    clear_inputs();
    live_m = 0;
    exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0));
    @(negedge clk);
    rst = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.command_valid_o === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL first_strobe got %0d required 8", lat);
    end
    $display("first strobe after %0d cycles", lat);
  endtask

  task automatic test_keepalive();
    logic [4:0] rl, re;
    for (int i = 1; i <= 31; i++) begin
      exp_q.push_back((i % 16 == 15) ? 32'h0000_0000 : IDLE);
      live_m = (i % 16 == 15) ? 0 : live_m + 1;
      drive_frame(0, 0, 14'h0, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0, rl, re);
      checks++;
      if ((rl | re) !== 5'b0) begin
        errors++; $display("FAIL idle_ready got %b required 00000", rl | re);
      end
    end
  endtask

  task automatic test_trigger();
    logic [4:0] rl, re;
    exp_q.push_back(model_word(1, 14'h1ABC, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0));
    drive_frame(2, 1, 14'h1ABC, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0, rl, re);
    checks++;
    if (re !== 5'b0) begin
      errors++; $display("FAIL trig_early_ready got %b required 00000", re);
    end
    checks++;
    if (rl !== 5'b10000) begin
      errors++; $display("FAIL trig_load_ready got %b required 10000", rl);
    end
    $display("trigger frame driven, load readies %b", rl);
  endtask

  task automatic test_run_and_cmd();
    logic [4:0] rl, re;
    exp_q.push_back(model_word(0, 14'h0, 1, 2'b01, 0, 8'h0, 0, 8'h0, 1, 8'h5A, 1));
    drive_frame(0, 0, 14'h0, 1, 2'b01, 0, 8'h0, 0, 8'h0, 1, 8'h5A, 1, rl, re);
    checks++;
    if (re !== 5'b0 || rl !== 5'b01001) begin
      errors++; $display("FAIL run_cmd_ready got %b/%b required 01001/00000", rl, re);
    end
    $display("runcmd+cmd frame driven, load readies %b", rl);
  endtask

  task automatic test_priority();
    logic [4:0] rl, re;
    exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 1, 8'h02, 1, 8'hA5, 1, 8'h11, 0));
    drive_frame(0, 0, 14'h0, 0, 2'b00, 1, 8'h02, 1, 8'hA5, 1, 8'h11, 0, rl, re);
    checks++;
    if (rl !== 5'b00100 || re !== 5'b0) begin
      errors++; $display("FAIL prio_special got %b/%b required 00100/00000", rl, re);
    end
    exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 0, 8'h0, 1, 8'hA5, 1, 8'h11, 0));
    drive_frame(0, 0, 14'h0, 0, 2'b00, 0, 8'h0, 1, 8'hA5, 1, 8'h11, 0, rl, re);
    checks++;
    if (rl !== 5'b00010 || re !== 5'b0) begin
      errors++; $display("FAIL prio_fw got %b/%b required 00010/00000", rl, re);
    end
    exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 0, 8'h0, 0, 8'h0, 1, 8'h11, 0));
    drive_frame(0, 0, 14'h0, 0, 2'b00, 0, 8'h0, 0, 8'h0, 1, 8'h11, 0, rl, re);
    checks++;
    if (rl !== 5'b00001 || re !== 5'b0) begin
      errors++; $display("FAIL prio_cmd got %b/%b required 00001/00000", rl, re);
    end
    $display("priority sequence driven");
  endtask

  task automatic test_back_to_back();
    logic [4:0] rl, re;
    logic [1:0] rc;
    logic [7:0] cd;
    for (int i = 0; i < 4; i++) begin
      rc = 2'(i);
      cd = 8'hC0 + 8'(i);
      exp_q.push_back(model_word(1, 14'(i * 14'h0111), 1, rc, 0, 8'h0, 0, 8'h0, 1, cd, rc[0]));
      drive_frame(0, 1, 14'(i * 14'h0111), 1, rc, 0, 8'h0, 0, 8'h0, 1, cd, rc[0], rl, re);
      checks++;
      if (rl !== 5'b11001 || re !== 5'b0) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b/%b required 11001/00000", i, rl, re);
      end
    end
    $display("back-to-back frames driven");
  endtask

  task automatic test_fw_stream();
    logic [4:0] rl, re;
    int accepted;
    int early_bad;
    accepted = 0;
    early_bad = 0;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 0, 8'h0, 1, 8'(i), 0, 8'h0, 0));
      drive_frame(0, 0, 14'h0, 0, 2'b00, 0, 8'h0, 1, 8'(i), 0, 8'h0, 0, rl, re);
      if (rl === 5'b00010) accepted++;
      if (re !== 5'b0) early_bad++;
    end
    checks++;
    if (accepted != 256) begin
      errors++; $display("FAIL fw_accepted got %0d required 256", accepted);
    end
    checks++;
    if (early_bad != 0) begin
      errors++; $display("FAIL fw_early_ready got %0d required 0", early_bad);
    end
    $display("fw stream of 256 bytes driven, accepted %0d", accepted);
  endtask

  task automatic test_async_reset();
    logic [4:0] rl, re;
    int lat;
    exp_q.push_back(model_word(1, 14'h0123, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0));
    drive_frame(0, 1, 14'h0123, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0, rl, re);
    bus.trig_time_i = 14'h0456;
    bus.trig_valid_i = 1;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (bus.command_o !== IDLE) begin
      errors++; $display("FAIL async_word got %08h required %08h", bus.command_o, IDLE);
    end
    checks++;
    if (bus.command_valid_o !== 1'b0 || readies() !== 5'b0) begin
      errors++; $display("FAIL async_outputs got %b/%b required 0/00000",
                         bus.command_valid_o, readies());
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    live_m = 0;
    exp_q.push_back(model_word(0, 14'h0, 0, 2'b00, 0, 8'h0, 0, 8'h0, 0, 8'h0, 0));
    rst = 0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.command_valid_o === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL async_first_strobe got %0d required 8", lat);
    end
    $display("async reset recovered, strobe after %0d cycles", lat);
  endtask

  initial begin
    bus.trig_time_i = '0; bus.runcmd_i = '0; bus.special_i = '0;
    bus.fw_tdata = '0; bus.cmd_tdata = '0;
    clear_inputs();
    test_reset();
    test_keepalive();
    test_trigger();
    test_run_and_cmd();
    test_priority();
    test_back_to_back();
    test_fw_stream();
    test_async_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
